stq_fwd_buffer: RTL and testbench
=================================

Name: stq_fwd_buffer

Overview:
- Parametrised store queue that succeeds the fixed two-wide store path in the 5-issue LSQ.
- Allocates up to ALLOC_W stores per cycle in program order.
- Captures address and data from the AGU, and marks stores committed by ROB tag (up to CMT_W per cycle).
- Drains committed stores to the D-cache through a valid/ready handshake, and answers a combinational store-to-load forwarding lookup.
- On flush, drops only uncommitted stores; committed stores survive and keep draining.

Parameters:
DEPTH, 8, number of store entries; any value >= 2, need not be a power of two
ALLOC_W, 2, dispatch allocation lanes per cycle
CMT_W, 2, commit lanes per cycle
TAG_W, 6, ROB tag width
XLEN, 32, address and data width; the byte mask is XLEN/8 bits

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  mispredict flush; discards uncommitted entries
rob_head  in  TAG_W  oldest in-flight ROB tag; used for age compare
alloc_we  in  ALLOC_W  per-lane allocate request
alloc_tag  in  ALLOC_W*TAG_W  ROB tag per lane; lane 0 is oldest
alloc_rdy  out  ALLOC_W  bit i = 1 when free entries >= i+1
res_valid  in  1  AGU store resolution
res_tag  in  TAG_W  tag of the resolved store
res_addr  in  XLEN  word-aligned address
res_data  in  XLEN  store data, byte-lane aligned
res_mask  in  XLEN/8  byte enables
cmt_valid  in  CMT_W  per-lane commit
cmt_tag  in  CMT_W*TAG_W  tags of committing stores
mem_req_valid  out  1  head store is ready to write
mem_req_addr  out  XLEN  head store address
mem_req_data  out  XLEN  head store data
mem_req_mask  out  XLEN/8  head store byte enables
mem_req_ready  in  1  cache accepts the write
ld_valid  in  1  forwarding lookup request
ld_tag  in  TAG_W  tag of the load
ld_addr  in  XLEN  word-aligned load address
ld_mask  in  XLEN/8  bytes the load needs
fwd_hit  out  1  all needed bytes supplied by a store
fwd_data  out  XLEN  forwarded data
fwd_stall  out  1  load must wait
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage: circular buffer with head, tail and commit pointers. Each pointer has a wrap bit and wraps at DEPTH-1 to 0. Per entry: valid, tag, addr_v, addr, data, mask, committed.
- Reset values: all entry valid bits 0; head, tail and commit pointers 0; count 0.
- Outputs after reset: alloc_rdy all 1s; mem_req_valid, fwd_hit and fwd_stall 0; mem_req_* and fwd_data 0.
- Allocation: lane i is accepted iff alloc_we[i] and alloc_rdy[i]. Dispatch guarantees alloc_we is prefix-contiguous (assertion, not recovery).
  - Accepted lanes fill tail, tail+1, ... in lane order.
  - New entry: valid=1, addr_v=0, committed=0.
  - Entries are visible to lookups next cycle.
- alloc_rdy is computed from registered count only. A same-cycle pop does not free space.
- Resolution: on res_valid, the valid entry whose tag == res_tag latches addr, data and mask and sets addr_v=1 at the clock edge.
  - No match: ignored.
  - At most one match is guaranteed.
- Commit: each cmt_valid lane sets committed on its tag-matching entry.
  - Committed entries are always contiguous from head; the commit pointer advances by the number of matched lanes.
  - A commit to an entry whose addr_v=0 is legal; that entry waits at head until resolved.
- Drain (combinational from head state):
  - mem_req_valid = head.valid & head.committed & head.addr_v, with mem_req_* taken from head.
  - On valid & ready, clear head and advance head at the edge.
  - Once valid is asserted, outputs hold stable until ready.
  - One pop per cycle.
- count: next = count + accepted allocs - pop. Simultaneous allocate and pop is legal, including when full: with count=DEPTH, a pop occurs but allocation is refused that cycle.
- Flush:
  - Tail is set to the commit pointer (post-commit value, so commits applied in the flush cycle count).
  - All uncommitted entries are invalidated; allocations in the flush cycle are ignored.
  - A pop and resolutions in the flush cycle still take effect for surviving entries.
  - count becomes the number of committed entries remaining.
- rst has priority over flush and over all other inputs.
- Age compare: store S is older than load L iff (S.tag - rob_head) < (ld_tag - rob_head), computed modulo 2^TAG_W.
- Forwarding (combinational, only when ld_valid; otherwise outputs are 0):
  - Candidates are valid entries older than the load.
  - If any candidate has addr_v=0: fwd_stall=1, fwd_hit=0.
  - Else, select the youngest candidate with addr==ld_addr and (mask & ld_mask) != 0.
  - If its mask covers ld_mask: fwd_hit=1 and fwd_data = its data.
  - If it only partially covers ld_mask: fwd_stall=1.
  - If there is no match: both 0, and the load reads the cache.
- Committed stores still in the queue remain forwarding candidates.

Test Plan:
1. Reset, then allocate tags 3,4 in one cycle; resolve tag 3 (addr 0x100, data 0xAABBCCDD, mask 0xF) and tag 4 (addr 0x104); commit 3 -> mem_req_valid with addr 0x100; ready=1 -> count goes 2->1, and the queue then waits on the commit of 4.
2. DEPTH=8: fill 8 entries -> alloc_rdy=00. Drain one with alloc_we=11 the same cycle -> nothing is allocated that cycle; alloc_rdy=01 the next cycle.
3. Entries 5(committed), 6, 7; flush together with cmt 6 -> entries 5 and 6 remain, count=2, tail = slot after 6, and 7 is absent from forwarding.
4. Store tag 2 (0x200, 0x11223344, mask 0xF) and store tag 5 (0x200, 0x55667788, mask 0xF); load tag 6 with mask 0xF -> fwd_hit=1, fwd_data=0x55667788. Load tag 4 -> 0x11223344.
5. Store tag 2 with addr unresolved; load tag 3 -> fwd_stall=1. A store with mask 0x3 and a load with mask 0xF at the same address -> fwd_stall=1.
6. Tag wrap with TAG_W=6 and rob_head=62: store tag 63, load tag 1 -> the store is treated as older and forwards. Pointer wrap: run 20 alloc/drain cycles with DEPTH=5 -> FIFO order is preserved.

Source files
------------

// File: rtl/stq_fwd_buffer.sv
// Store queue: in-order allocate, AGU resolve, ROB commit, in-order drain to D-cache, store-to-load forwarding.
// Latency: allocate/resolve/commit/flush update state at the next edge; drain request and forwarding are combinational.
// Backpressure: o_alloc_rdy derives from registered count only; the head store holds o_mem_req_* until i_mem_req_ready.
module stq_fwd_buffer #(
  parameter int DEPTH   = 8,
  parameter int ALLOC_W = 2,
  parameter int CMT_W   = 2,
  parameter int TAG_W   = 6,
  parameter int XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic [TAG_W-1:0]           i_rob_head,
  input  logic [ALLOC_W-1:0]         i_alloc_we,
  input  logic [ALLOC_W*TAG_W-1:0]   i_alloc_tag,
  output logic [ALLOC_W-1:0]         o_alloc_rdy,
  input  logic                       i_res_valid,
  input  logic [TAG_W-1:0]           i_res_tag,
  input  logic [XLEN-1:0]            i_res_addr,
  input  logic [XLEN-1:0]            i_res_data,
  input  logic [XLEN/8-1:0]          i_res_mask,
  input  logic [CMT_W-1:0]           i_cmt_valid,
  input  logic [CMT_W*TAG_W-1:0]     i_cmt_tag,
  output logic                       o_mem_req_valid,
  output logic [XLEN-1:0]            o_mem_req_addr,
  output logic [XLEN-1:0]            o_mem_req_data,
  output logic [XLEN/8-1:0]          o_mem_req_mask,
  input  logic                       i_mem_req_ready,
  input  logic                       i_ld_valid,
  input  logic [TAG_W-1:0]           i_ld_tag,
  input  logic [XLEN-1:0]            i_ld_addr,
  input  logic [XLEN/8-1:0]          i_ld_mask,
  output logic                       o_fwd_hit,
  output logic [XLEN-1:0]            o_fwd_data,
  output logic                       o_fwd_stall,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int MW = XLEN/8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic             vld;
    logic             cmt;
    logic             av;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [MW-1:0]    mask;
  } ent_t;

  // Index plus wrap bit so full and empty are distinguishable for any DEPTH.
  typedef struct packed {
    logic          wrap;
    logic [PW-1:0] idx;
  } ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t n;
    if (p.idx == PW'(DEPTH-1)) begin
      n.idx  = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.idx  = p.idx + PW'(1);
      n.wrap = p.wrap;
    end
    return n;
  endfunction

  // Number of slots from 'from' up to (not including) 'to'.
  function automatic logic [CW-1:0] ptr_dist(input ptr_t from, input ptr_t to);
    if (from.wrap == to.wrap) return CW'(to.idx) - CW'(from.idx);
    else                      return CW'(DEPTH) - CW'(from.idx) + CW'(to.idx);
  endfunction

  ent_t               r_ent [DEPTH];
  ptr_t               r_head;
  ptr_t               r_tail;
  ptr_t               r_cptr;
  logic [CW-1:0]      r_count;

  ptr_t               w_lane_ptr [ALLOC_W];
  ptr_t               w_tail_alloc;
  ptr_t               w_tail_nxt;
  ptr_t               w_head_nxt;
  ptr_t               w_cptr_nxt;
  logic [ALLOC_W-1:0] w_acc;
  logic [CW-1:0]      w_n_acc;
  logic [CMT_W-1:0]   w_cmt_lane_hit;
  logic [DEPTH-1:0]   w_cmt_hit;
  logic [DEPTH-1:0]   w_res_hit;
  ent_t               w_head_ent;
  logic               w_pop;
  logic [CW-1:0]      w_count_nxt;

  assign o_count = r_count;

  // Lane i may allocate when at least i+1 slots were free at the last edge.
  always_comb begin
    for (int i = 0; i < ALLOC_W; i++) begin
      o_alloc_rdy[i] = (int'(r_count) + i + 1) <= DEPTH;
    end
  end

  // Accepted lanes take consecutive slots from tail; flush cancels all allocation.
  always_comb begin
    ptr_t p;
    p       = r_tail;
    w_n_acc = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      w_lane_ptr[i] = p;
      w_acc[i]      = i_alloc_we[i] & o_alloc_rdy[i] & ~i_flush;
      if (w_acc[i]) begin
        p       = ptr_inc(p);
        w_n_acc = w_n_acc + CW'(1);
      end
    end
    w_tail_alloc = p;
  end

  // Tag match for resolution and commit; commit pointer advances once per matched lane.
  always_comb begin
    ptr_t p;
    w_res_hit      = '0;
    w_cmt_hit      = '0;
    w_cmt_lane_hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      w_res_hit[e] = i_res_valid & r_ent[e].vld & (r_ent[e].tag == i_res_tag);
      for (int j = 0; j < CMT_W; j++) begin
        if (i_cmt_valid[j] && r_ent[e].vld && (r_ent[e].tag == i_cmt_tag[j*TAG_W +: TAG_W])) begin
          w_cmt_hit[e]      = 1'b1;
          w_cmt_lane_hit[j] = 1'b1;
        end
      end
    end
    p = r_cptr;
    for (int j = 0; j < CMT_W; j++) begin
      if (w_cmt_lane_hit[j]) p = ptr_inc(p);
    end
    w_cptr_nxt = p;
  end

  // Drain request straight from head state; fields forced to zero when idle.
  assign w_head_ent      = r_ent[r_head.idx];
  assign o_mem_req_valid = w_head_ent.vld & w_head_ent.cmt & w_head_ent.av;
  assign o_mem_req_addr  = o_mem_req_valid ? w_head_ent.addr : '0;
  assign o_mem_req_data  = o_mem_req_valid ? w_head_ent.data : '0;
  assign o_mem_req_mask  = o_mem_req_valid ? w_head_ent.mask : '0;
  assign w_pop           = o_mem_req_valid & i_mem_req_ready;

  // On flush the queue shrinks back to the committed prefix, which survives intact.
  assign w_head_nxt  = w_pop ? ptr_inc(r_head) : r_head;
  assign w_tail_nxt  = i_flush ? w_cptr_nxt : w_tail_alloc;
  assign w_count_nxt = i_flush ? ptr_dist(w_head_nxt, w_cptr_nxt)
                               : r_count + w_n_acc - CW'(w_pop);

  // Entry and pointer state update; allocation writes last since it targets free slots only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) r_ent[e] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_cptr  <= '0;
      r_count <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_res_hit[e]) begin
          r_ent[e].av   <= 1'b1;
          r_ent[e].addr <= i_res_addr;
          r_ent[e].data <= i_res_data;
          r_ent[e].mask <= i_res_mask;
        end
        if (w_cmt_hit[e]) r_ent[e].cmt <= 1'b1;
        if (i_flush && !(r_ent[e].cmt || w_cmt_hit[e])) r_ent[e].vld <= 1'b0;
        if (w_pop && (r_head.idx == PW'(e))) begin
          r_ent[e].vld <= 1'b0;
          r_ent[e].cmt <= 1'b0;
          r_ent[e].av  <= 1'b0;
        end
      end
      for (int i = 0; i < ALLOC_W; i++) begin
        if (w_acc[i]) begin
          r_ent[w_lane_ptr[i].idx].vld <= 1'b1;
          r_ent[w_lane_ptr[i].idx].cmt <= 1'b0;
          r_ent[w_lane_ptr[i].idx].av  <= 1'b0;
          r_ent[w_lane_ptr[i].idx].tag <= i_alloc_tag[i*TAG_W +: TAG_W];
        end
      end
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_cptr  <= w_cptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Forwarding: any older unresolved store stalls; otherwise youngest overlapping older store decides.
  always_comb begin
    logic [TAG_W-1:0] ld_age;
    logic [TAG_W-1:0] e_age;
    logic [TAG_W-1:0] best_age;
    logic             found;
    logic             unres;
    ent_t             best;
    ld_age      = i_ld_tag - i_rob_head;
    e_age       = '0;
    best_age    = '0;
    found       = 1'b0;
    unres       = 1'b0;
    best        = '0;
    o_fwd_hit   = 1'b0;
    o_fwd_stall = 1'b0;
    o_fwd_data  = '0;
    for (int e = 0; e < DEPTH; e++) begin
      e_age = r_ent[e].tag - i_rob_head;
      if (r_ent[e].vld && (e_age < ld_age)) begin
        if (!r_ent[e].av) begin
          unres = 1'b1;
        end else if ((r_ent[e].addr == i_ld_addr) && ((r_ent[e].mask & i_ld_mask) != '0)
                     && (!found || (e_age > best_age))) begin
          found    = 1'b1;
          best_age = e_age;
          best     = r_ent[e];
        end
      end
    end
    if (i_ld_valid) begin
      if (unres) begin
        o_fwd_stall = 1'b1;
      end else if (found) begin
        if ((best.mask & i_ld_mask) == i_ld_mask) begin
          o_fwd_hit  = 1'b1;
          o_fwd_data = best.data;
        end else begin
          o_fwd_stall = 1'b1;
        end
      end
    end
  end

  // Dispatch fills lanes from lane 0 upward with no holes.
  assert property (@(posedge clk) disable iff (rst)
    ((i_alloc_we & (i_alloc_we + ALLOC_W'(1))) == '0));

endmodule

// File: tb/tb_stq_fwd_buffer.sv
// Bench for stq_fwd_buffer: DEPTH=8 instance for the main scenarios, DEPTH=5 instance for pointer wrap.
// Expected drain writes and forwarding results are queued by the stimulus and popped by monitors.
// Counts and ready flags are compared directly after the relevant edge.
module tb_stq_fwd_buffer;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } mem_t;

  typedef struct packed {
    logic        hit;
    logic        stall;
    logic [31:0] data;
  } fwd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  mem_t        mem8_q[$];
  mem_t        mem5_q[$];
  fwd_t        fwd_q[$];

  // DEPTH=8 instance signals
  logic        flush = 1'b0;
  logic [5:0]  rob_head = '0;
  logic [1:0]  alloc_we = '0;
  logic [11:0] alloc_tag = '0;
  logic [1:0]  alloc_rdy;
  logic        res_valid = 1'b0;
  logic [5:0]  res_tag = '0;
  logic [31:0] res_addr = '0;
  logic [31:0] res_data = '0;
  logic [3:0]  res_mask = '0;
  logic [1:0]  cmt_valid = '0;
  logic [11:0] cmt_tag = '0;
  logic        mreq_v;
  logic [31:0] mreq_a;
  logic [31:0] mreq_d;
  logic [3:0]  mreq_m;
  logic        mreq_rdy = 1'b0;
  logic        ld_valid = 1'b0;
  logic [5:0]  ld_tag = '0;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_mask = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic [3:0]  count8;

  // DEPTH=5 instance signals
  logic [1:0]  alloc_we5 = '0;
  logic [11:0] alloc_tag5 = '0;
  logic [1:0]  alloc_rdy5;
  logic        res_valid5 = 1'b0;
  logic [5:0]  res_tag5 = '0;
  logic [31:0] res_addr5 = '0;
  logic [31:0] res_data5 = '0;
  logic [1:0]  cmt_valid5 = '0;
  logic [11:0] cmt_tag5 = '0;
  logic        mreq_v5;
  logic [31:0] mreq_a5;
  logic [31:0] mreq_d5;
  logic [3:0]  mreq_m5;
  logic        mreq_rdy5 = 1'b1;
  logic        fwd_hit5;
  logic [31:0] fwd_data5;
  logic        fwd_stall5;
  logic [2:0]  count5;

  always #5 clk = ~clk;

  stq_fwd_buffer #(.DEPTH(8), .ALLOC_W(2), .CMT_W(2), .TAG_W(6), .XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_rob_head(rob_head),
    .i_alloc_we(alloc_we), .i_alloc_tag(alloc_tag), .o_alloc_rdy(alloc_rdy),
    .i_res_valid(res_valid), .i_res_tag(res_tag), .i_res_addr(res_addr),
    .i_res_data(res_data), .i_res_mask(res_mask),
    .i_cmt_valid(cmt_valid), .i_cmt_tag(cmt_tag),
    .o_mem_req_valid(mreq_v), .o_mem_req_addr(mreq_a), .o_mem_req_data(mreq_d),
    .o_mem_req_mask(mreq_m), .i_mem_req_ready(mreq_rdy),
    .i_ld_valid(ld_valid), .i_ld_tag(ld_tag), .i_ld_addr(ld_addr), .i_ld_mask(ld_mask),
    .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data), .o_fwd_stall(fwd_stall), .o_count(count8)
  );

  stq_fwd_buffer #(.DEPTH(5), .ALLOC_W(2), .CMT_W(2), .TAG_W(6), .XLEN(32)) u_dut5 (
    .clk(clk), .rst(rst), .i_flush(1'b0), .i_rob_head(6'd0),
    .i_alloc_we(alloc_we5), .i_alloc_tag(alloc_tag5), .o_alloc_rdy(alloc_rdy5),
    .i_res_valid(res_valid5), .i_res_tag(res_tag5), .i_res_addr(res_addr5),
    .i_res_data(res_data5), .i_res_mask(4'hF),
    .i_cmt_valid(cmt_valid5), .i_cmt_tag(cmt_tag5),
    .o_mem_req_valid(mreq_v5), .o_mem_req_addr(mreq_a5), .o_mem_req_data(mreq_d5),
    .o_mem_req_mask(mreq_m5), .i_mem_req_ready(mreq_rdy5),
    .i_ld_valid(1'b0), .i_ld_tag(6'd0), .i_ld_addr(32'd0), .i_ld_mask(4'd0),
    .o_fwd_hit(fwd_hit5), .o_fwd_data(fwd_data5), .o_fwd_stall(fwd_stall5), .o_count(count5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_alloc(input logic [1:0] we, input logic [5:0] t0, input logic [5:0] t1);
    alloc_we  = we;
    alloc_tag = {t1, t0};
    tick();
    alloc_we  = '0;
  endtask

  task automatic do_res(input logic [5:0] tag, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
    res_valid = 1'b1;
    res_tag   = tag;
    res_addr  = addr;
    res_data  = data;
    res_mask  = mask;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic do_cmt(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1);
    cmt_valid = v;
    cmt_tag   = {t1, t0};
    tick();
    cmt_valid = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic exp_mem8(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    mem_t m;
    m.addr = addr;
    m.data = data;
    m.mask = mask;
    mem8_q.push_back(m);
  endtask

  task automatic do_load(input logic [5:0] tag, input logic [31:0] addr, input logic [3:0] mask,
                         input logic hit, input logic stall, input logic [31:0] data);
    fwd_t f;
    f.hit   = hit;
    f.stall = stall;
    f.data  = data;
    fwd_q.push_back(f);
    ld_valid = 1'b1;
    ld_tag   = tag;
    ld_addr  = addr;
    ld_mask  = mask;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic wait_empty8(input int budget);
    int n;
    n = 0;
    while (count8 != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain8_empty", 32'(count8), 32'd0);
  endtask

  // Drain monitor, DEPTH=8: every accepted write must match the next expected one.
  initial begin : mon_mem8
    mem_t e;
    forever begin
      @(negedge clk);
      if (!rst && mreq_v && mreq_rdy) begin
        checks++;
        if (mem8_q.size() == 0) begin
          errors++;
          $display("FAIL mem8_unexpected actual_addr=0x%0h required=none", mreq_a);
        end else begin
          e = mem8_q.pop_front();
          if ({mreq_a, mreq_d, mreq_m} !== e) begin
            errors++;
            $display("FAIL mem8_write actual=%h/%h/%h required=%h/%h/%h",
                     mreq_a, mreq_d, mreq_m, e.addr, e.data, e.mask);
          end
        end
      end
    end
  end

  // Drain monitor, DEPTH=5.
  initial begin : mon_mem5
    mem_t e;
    forever begin
      @(negedge clk);
      if (!rst && mreq_v5 && mreq_rdy5) begin
        checks++;
        if (mem5_q.size() == 0) begin
          errors++;
          $display("FAIL mem5_unexpected actual_addr=0x%0h required=none", mreq_a5);
        end else begin
          e = mem5_q.pop_front();
          if ({mreq_a5, mreq_d5, mreq_m5} !== e) begin
            errors++;
            $display("FAIL mem5_write actual=%h/%h/%h required=%h/%h/%h",
                     mreq_a5, mreq_d5, mreq_m5, e.addr, e.data, e.mask);
          end
        end
      end
    end
  end

  // Forwarding monitor: compares each presented load lookup.
  initial begin : mon_fwd
    fwd_t e;
    forever begin
      @(negedge clk);
      if (!rst && ld_valid) begin
        checks++;
        if (fwd_q.size() == 0) begin
          errors++;
          $display("FAIL fwd_unexpected actual_tag=%0d required=none", ld_tag);
        end else begin
          e = fwd_q.pop_front();
          if ({fwd_hit, fwd_stall, fwd_data} !== e) begin
            errors++;
            $display("FAIL fwd tag=%0d addr=0x%0h actual hit=%0b stall=%0b data=0x%0h required hit=%0b stall=%0b data=0x%0h",
                     ld_tag, ld_addr, fwd_hit, fwd_stall, fwd_data, e.hit, e.stall, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    mem_t m5;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_count8", 32'(count8), 32'd0);
    check("rst_rdy8", 32'(alloc_rdy), 32'd3);
    check("rst_mreq_v", 32'(mreq_v), 32'd0);
    check("rst_mreq_addr", mreq_a, 32'd0);
    check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    check("rst_fwd_stall", 32'(fwd_stall), 32'd0);
    check("rst_count5", 32'(count5), 32'd0);
    check("rst_rdy5", 32'(alloc_rdy5), 32'd3);

    // 1: allocate 3,4; resolve; commit 3 drains; 4 waits for its commit
    mreq_rdy = 1'b1;
    do_alloc(2'b11, 6'd3, 6'd4);
    check("t1_count_alloc", 32'(count8), 32'd2);
    do_res(6'd3, 32'h100, 32'hAABBCCDD, 4'hF);
    do_res(6'd4, 32'h104, 32'h12345678, 4'hF);
    check("t1_no_req_uncommitted", 32'(mreq_v), 32'd0);
    exp_mem8(32'h100, 32'hAABBCCDD, 4'hF);
    do_cmt(2'b01, 6'd3, 6'd0);
    check("t1_req_valid", 32'(mreq_v), 32'd1);
    check("t1_req_addr", mreq_a, 32'h100);
    check("t1_count_before_pop", 32'(count8), 32'd2);
    tick();
    check("t1_count_after_pop", 32'(count8), 32'd1);
    check("t1_wait_cmt4", 32'(mreq_v), 32'd0);
    tick();
    check("t1_still_wait", 32'(mreq_v), 32'd0);
    exp_mem8(32'h104, 32'h12345678, 4'hF);
    do_cmt(2'b01, 6'd4, 6'd0);
    tick();
    check("t1_count_empty", 32'(count8), 32'd0);
    mreq_rdy = 1'b0;

    // 2: fill 8, pop with alloc_we=11 while full -> no allocation that cycle
    for (int k = 0; k < 4; k++) do_alloc(2'b11, 6'(10 + 2*k), 6'(11 + 2*k));
    check("t2_count_full", 32'(count8), 32'd8);
    check("t2_rdy_full", 32'(alloc_rdy), 32'd0);
    do_res(6'd10, 32'h300, 32'hDEAD0010, 4'hF);
    exp_mem8(32'h300, 32'hDEAD0010, 4'hF);
    do_cmt(2'b01, 6'd10, 6'd0);
    mreq_rdy = 1'b1;
    do_alloc(2'b11, 6'd20, 6'd21);
    mreq_rdy = 1'b0;
    check("t2_count_after_pop", 32'(count8), 32'd7);
    check("t2_rdy_after_pop", 32'(alloc_rdy), 32'd1);
    do_flush();
    check("t2_flush_count", 32'(count8), 32'd0);

    // 3: 5 committed, 6 and 7 in flight; flush with commit of 6
    do_alloc(2'b11, 6'd5, 6'd6);
    do_alloc(2'b01, 6'd7, 6'd0);
    do_cmt(2'b01, 6'd5, 6'd0);
    do_res(6'd5, 32'h600, 32'h55550000, 4'hF);
    do_res(6'd6, 32'h500, 32'h66660000, 4'hF);
    do_res(6'd7, 32'h400, 32'h77770000, 4'hF);
    check("t3_count_pre", 32'(count8), 32'd3);
    flush = 1'b1;
    cmt_valid = 2'b01;
    cmt_tag = {6'd0, 6'd6};
    tick();
    flush = 1'b0;
    cmt_valid = '0;
    check("t3_count_flush", 32'(count8), 32'd2);
    check("t3_rdy_flush", 32'(alloc_rdy), 32'd3);
    do_load(6'd9, 32'h400, 4'hF, 1'b0, 1'b0, 32'h0);
    do_load(6'd9, 32'h500, 4'hF, 1'b1, 1'b0, 32'h66660000);
    do_alloc(2'b01, 6'd8, 6'd0);
    check("t3_count_realloc", 32'(count8), 32'd3);
    do_res(6'd8, 32'h400, 32'h88880000, 4'hF);
    do_load(6'd9, 32'h400, 4'hF, 1'b1, 1'b0, 32'h88880000);
    do_cmt(2'b01, 6'd8, 6'd0);
    exp_mem8(32'h600, 32'h55550000, 4'hF);
    exp_mem8(32'h500, 32'h66660000, 4'hF);
    exp_mem8(32'h400, 32'h88880000, 4'hF);
    mreq_rdy = 1'b1;
    wait_empty8(20);
    mreq_rdy = 1'b0;

    // 4: youngest older store forwards
    do_alloc(2'b11, 6'd2, 6'd5);
    do_res(6'd2, 32'h200, 32'h11223344, 4'hF);
    do_res(6'd5, 32'h200, 32'h55667788, 4'hF);
    do_load(6'd6, 32'h200, 4'hF, 1'b1, 1'b0, 32'h55667788);
    do_load(6'd4, 32'h200, 4'hF, 1'b1, 1'b0, 32'h11223344);
    do_load(6'd1, 32'h200, 4'hF, 1'b0, 1'b0, 32'h0);
    do_load(6'd6, 32'h200, 4'h3, 1'b1, 1'b0, 32'h55667788);
    do_flush();
    check("t4_flush_count", 32'(count8), 32'd0);

    // 5: unresolved older store and partial coverage both stall
    do_alloc(2'b01, 6'd2, 6'd0);
    do_load(6'd3, 32'h200, 4'hF, 1'b0, 1'b1, 32'h0);
    do_res(6'd2, 32'h700, 32'h0000BEEF, 4'h3);
    do_load(6'd3, 32'h700, 4'hF, 1'b0, 1'b1, 32'h0);
    do_load(6'd3, 32'h700, 4'h3, 1'b1, 1'b0, 32'h0000BEEF);
    do_load(6'd3, 32'h700, 4'hC, 1'b0, 1'b0, 32'h0);
    do_flush();

    // 6: tag wrap in age compare
    rob_head = 6'd62;
    do_alloc(2'b01, 6'd63, 6'd0);
    do_res(6'd63, 32'h800, 32'h0BADF00D, 4'hF);
    do_load(6'd1, 32'h800, 4'hF, 1'b1, 1'b0, 32'h0BADF00D);
    do_load(6'd62, 32'h800, 4'hF, 1'b0, 1'b0, 32'h0);
    do_flush();
    rob_head = 6'd0;
    check("t6_flush_count", 32'(count8), 32'd0);

    // 6b: DEPTH=5 pointer wrap, 20 stores in FIFO order
    for (int k = 0; k < 10; k++) begin
      alloc_we5  = 2'b11;
      alloc_tag5 = {6'(2*k + 1), 6'(2*k)};
      tick();
      alloc_we5 = '0;
      for (int s = 0; s < 2; s++) begin
        res_valid5 = 1'b1;
        res_tag5   = 6'(2*k + s);
        res_addr5  = 32'h1000 + 32'(8*k + 4*s);
        res_data5  = 32'hC0DE0000 + 32'(2*k + s);
        m5.addr = res_addr5;
        m5.data = res_data5;
        m5.mask = 4'hF;
        mem5_q.push_back(m5);
        tick();
        res_valid5 = 1'b0;
      end
      cmt_valid5 = 2'b11;
      cmt_tag5   = {6'(2*k + 1), 6'(2*k)};
      tick();
      cmt_valid5 = '0;
    end
    repeat (4) tick();
    check("t6_count5_empty", 32'(count5), 32'd0);

    tick();
    check("mem8_all_drained", 32'(mem8_q.size()), 32'd0);
    check("mem5_all_drained", 32'(mem5_q.size()), 32'd0);
    check("fwd_all_seen", 32'(fwd_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
